// File: rtl/axis_priority_packet_arbiter.sv
// ============================================================================
// Module  : axis_priority_packet_arbiter
// Brief   : Two-class packet arbiter for AXI-stream with LP starvation guard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_priority_packet_arbiter #(
  parameter int                  DATA_WIDTH       = 32,
  parameter int                  N_INPUTS         = 4,
  parameter logic [N_INPUTS-1:0] HP_MASK          = 4'b0001,
  parameter int                  STARVATION_LIMIT = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [N_INPUTS-1:0]            data_in_valid,
  input  logic [N_INPUTS-1:0]            data_in_tlast,
  output logic [N_INPUTS-1:0]            data_in_ready,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           data_out_valid,
  output logic                           data_out_tlast,
  input  logic                           data_out_ready,
  output logic [$clog2(N_INPUTS)-1:0]    grant_index,
  output logic                           busy
);

  localparam int c_ptr_w = $clog2(N_INPUTS);
  localparam int c_cnt_w = $clog2(STARVATION_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVATION_LIMIT);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(N_INPUTS - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               r_state, w_state_next;
  logic [c_ptr_w-1:0]   r_grant, w_grant_next;
  logic [c_ptr_w-1:0]   r_hp_ptr, w_hp_ptr_next;
  logic [c_ptr_w-1:0]   r_lp_ptr, w_lp_ptr_next;
  logic [c_cnt_w-1:0]   r_starve_cnt, w_starve_next;
  logic [N_INPUTS-1:0]  w_hp_req, w_lp_req;
  logic [c_ptr_w-1:0]   w_hp_pick, w_lp_pick;
  logic                 w_packet_end;
  logic [DATA_WIDTH-1:0] w_lanes [N_INPUTS];

  generate
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
      assign w_lanes[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  function automatic logic [c_ptr_w-1:0] f_next_idx(input logic [c_ptr_w-1:0] idx);
    return (idx == c_last) ? '0 : idx + 1'b1;
  endfunction

  // First requester at or above ptr, wrapping; ptr is returned when req is empty.
  function automatic logic [c_ptr_w-1:0] f_rr_pick(input logic [N_INPUTS-1:0] req,
                                                   input logic [c_ptr_w-1:0]  ptr);
    logic [c_ptr_w-1:0] idx;
    logic [c_ptr_w-1:0] pick;
    logic               found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = f_next_idx(idx);
    end
    return pick;
  endfunction

  assign w_hp_req     = data_in_valid & HP_MASK;
  assign w_lp_req     = data_in_valid & ~HP_MASK;
  assign w_hp_pick    = f_rr_pick(w_hp_req, r_hp_ptr);
  assign w_lp_pick    = f_rr_pick(w_lp_req, r_lp_ptr);
  assign w_packet_end = data_in_valid[r_grant] & data_in_tlast[r_grant] & data_out_ready;

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_hp_ptr_next  = r_hp_ptr;
    w_lp_ptr_next  = r_lp_ptr;
    w_starve_next  = r_starve_cnt;
    data_out       = '0;
    data_out_valid = 1'b0;
    data_out_tlast = 1'b0;
    data_in_ready  = '0;
    case (r_state)
      S_IDLE: begin
        if (|data_in_valid) begin
          w_state_next = S_LOCKED;
          if ((r_starve_cnt == c_limit) && (|w_lp_req)) begin
            w_grant_next  = w_lp_pick;
            w_lp_ptr_next = f_next_idx(w_lp_pick);
            w_starve_next = '0;
          end else if (|w_hp_req) begin
            w_grant_next  = w_hp_pick;
            w_hp_ptr_next = f_next_idx(w_hp_pick);
            // Count only HP wins that actually made an LP requester wait.
            if (|w_lp_req)
              w_starve_next = (r_starve_cnt == c_limit) ? r_starve_cnt : r_starve_cnt + 1'b1;
            else
              w_starve_next = '0;
          end else begin
            w_grant_next  = w_lp_pick;
            w_lp_ptr_next = f_next_idx(w_lp_pick);
            w_starve_next = '0;
          end
        end
      end
      S_LOCKED: begin
        data_out               = w_lanes[r_grant];
        data_out_valid         = data_in_valid[r_grant];
        data_out_tlast         = data_in_tlast[r_grant];
        data_in_ready[r_grant] = data_out_ready;
        if (w_packet_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_hp_ptr     <= '0;
      r_lp_ptr     <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_hp_ptr     <= w_hp_ptr_next;
      r_lp_ptr     <= w_lp_ptr_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  assign grant_index = r_grant;
  assign busy        = (r_state == S_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_axis_priority_packet_arbiter.sv
// ============================================================================
// Module  : tb_axis_priority_packet_arbiter
// Brief   : Vector table, directed sequences and randomized model comparison.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_priority_packet_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int LIMIT = 8;
  localparam logic [N-1:0] HP = 4'b0001;

  logic              clock;
  logic              reset;
  logic [N-1:0][DW-1:0] din;
  logic [N-1:0]      vin, tin, rdy;
  logic [DW-1:0]     dout;
  logic              ovalid, otlast, oready;
  logic [1:0]        gidx;
  logic              busy;

  int tests = 0;
  int fails = 0;

  axis_priority_packet_arbiter #(
    .DATA_WIDTH(DW), .N_INPUTS(N), .HP_MASK(HP), .STARVATION_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset(reset), .data_in(din), .data_in_valid(vin),
    .data_in_tlast(tin), .data_in_ready(rdy), .data_out(dout),
    .data_out_valid(ovalid), .data_out_tlast(otlast), .data_out_ready(oready),
    .grant_index(gidx), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural reference: arbitration decided from the class rules with ints.
  typedef struct {
    bit locked;
    int grant;
    int hp_ptr;
    int lp_ptr;
    int starve;
  } model_t;

  model_t m;

  function automatic int rr(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic rst_n,
                                        input logic [N-1:0] v, input logic [N-1:0] t,
                                        input logic r);
    model_t nx;
    logic [N-1:0] hp, lp;
    int g;
    nx = cur;
    hp = v & HP;
    lp = v & ~HP;
    if (!rst_n) begin
      nx.locked = 0; nx.grant = 0; nx.hp_ptr = 0; nx.lp_ptr = 0; nx.starve = 0;
    end else if (!cur.locked) begin
      if (v != 0) begin
        if (cur.starve == LIMIT && lp != 0) begin
          g = rr(lp, cur.lp_ptr); nx.lp_ptr = (g + 1) % N; nx.starve = 0;
        end else if (hp != 0) begin
          g = rr(hp, cur.hp_ptr); nx.hp_ptr = (g + 1) % N;
          nx.starve = (lp != 0) ? ((cur.starve + 1 > LIMIT) ? LIMIT : cur.starve + 1) : 0;
        end else begin
          g = rr(lp, cur.lp_ptr); nx.lp_ptr = (g + 1) % N; nx.starve = 0;
        end
        nx.grant  = g;
        nx.locked = 1;
      end
    end else if (v[cur.grant] && t[cur.grant] && r) begin
      nx.locked = 0;
    end
    return nx;
  endfunction

  always @(posedge clock) m <= model_next(m, reset, vin, tin, oready);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle: inputs change just after the edge, outputs sampled on the falling edge.
  task automatic step(input logic rst_n, input logic [N-1:0] v, input logic [N-1:0] t,
                      input logic [DW-1:0] d, input logic r);
    @(posedge clock);
    #1;
    reset  = rst_n;
    vin    = v;
    tin    = t;
    oready = r;
    for (int i = 0; i < N; i++) din[i] = d ^ (DW'(i) << 28);
    @(negedge clock);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
  endtask

  typedef struct {
    logic         rst_n;
    logic [N-1:0] v, t;
    logic [DW-1:0] d;
    logic         r;
    logic         e_busy;
    logic [1:0]   e_grant;
    logic         e_valid, e_tlast;
    logic [N-1:0] e_rdy;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int got[$];
    int viol;
    bit prev;
    logic [N-1:0] v, t;
    logic [DW-1:0] d;
    logic rs, r;
    int g;

    reset = 1'b0; vin = '0; tin = '0; oready = 1'b0; din = '0;

    // 3-beat packet on input 2, then a 4-beat packet on input 1 with ready toggling,
    // then simultaneous HP/LP request.
    tbl.push_back('{1, 4'b0100, 4'b0000, 32'hA, 1, 0, 0, 0, 0, 4'b0000, 32'h0});
    tbl.push_back('{1, 4'b0100, 4'b0000, 32'hA, 1, 1, 2, 1, 0, 4'b0100, 32'h2000000A});
    tbl.push_back('{1, 4'b0100, 4'b0000, 32'hB, 1, 1, 2, 1, 0, 4'b0100, 32'h2000000B});
    tbl.push_back('{1, 4'b0100, 4'b0100, 32'hC, 1, 1, 2, 1, 1, 4'b0100, 32'h2000000C});
    tbl.push_back('{1, 4'b0000, 4'b0000, 32'h0, 1, 0, 2, 0, 0, 4'b0000, 32'h0});
    tbl.push_back('{1, 4'b0010, 4'b0000, 32'h1, 1, 0, 2, 0, 0, 4'b0000, 32'h0});
    tbl.push_back('{1, 4'b0010, 4'b0000, 32'h1, 1, 1, 1, 1, 0, 4'b0010, 32'h10000001});
    tbl.push_back('{1, 4'b0010, 4'b0000, 32'h2, 0, 1, 1, 1, 0, 4'b0000, 32'h10000002});
    tbl.push_back('{1, 4'b0010, 4'b0000, 32'h2, 1, 1, 1, 1, 0, 4'b0010, 32'h10000002});
    tbl.push_back('{1, 4'b0010, 4'b0000, 32'h3, 0, 1, 1, 1, 0, 4'b0000, 32'h10000003});
    tbl.push_back('{1, 4'b0010, 4'b0000, 32'h3, 1, 1, 1, 1, 0, 4'b0010, 32'h10000003});
    tbl.push_back('{1, 4'b0010, 4'b0010, 32'h4, 0, 1, 1, 1, 1, 4'b0000, 32'h10000004});
    tbl.push_back('{1, 4'b0010, 4'b0010, 32'h4, 1, 1, 1, 1, 1, 4'b0010, 32'h10000004});
    tbl.push_back('{1, 4'b0000, 4'b0000, 32'h0, 1, 0, 1, 0, 0, 4'b0000, 32'h0});
    tbl.push_back('{1, 4'b0011, 4'b0011, 32'h5, 1, 0, 1, 0, 0, 4'b0000, 32'h0});
    tbl.push_back('{1, 4'b0011, 4'b0011, 32'h5, 1, 1, 0, 1, 1, 4'b0001, 32'h00000005});
    tbl.push_back('{1, 4'b0000, 4'b0000, 32'h0, 1, 0, 0, 0, 0, 4'b0000, 32'h0});

    do_reset();
    check("reset_busy",  64'(busy),   64'd0);
    check("reset_grant", 64'(gidx),   64'd0);
    check("reset_ready", 64'(rdy),    64'd0);
    check("reset_valid", 64'(ovalid), 64'd0);
    check("reset_tlast", 64'(otlast), 64'd0);
    check("reset_data",  64'(dout),   64'd0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].v, tbl[i].t, tbl[i].d, tbl[i].r);
      check($sformatf("vec%0d_busy", i),  64'(busy),   64'(tbl[i].e_busy));
      check($sformatf("vec%0d_grant", i), 64'(gidx),   64'(tbl[i].e_grant));
      check($sformatf("vec%0d_valid", i), 64'(ovalid), 64'(tbl[i].e_valid));
      check($sformatf("vec%0d_tlast", i), 64'(otlast), 64'(tbl[i].e_tlast));
      check($sformatf("vec%0d_ready", i), 64'(rdy),    64'(tbl[i].e_rdy));
      check($sformatf("vec%0d_data", i),  64'(dout),   64'(tbl[i].e_data));
    end

    // LP-only round robin with single-beat packets.
    do_reset();
    got.delete(); viol = 0; prev = 0;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      step(1'b1, 4'b1110, 4'b1110, 32'h0, 1'b1);
      if (busy) begin
        got.push_back(int'(gidx));
        if (prev) viol++;
      end
      prev = busy;
    end
    check("rr_count", 64'(got.size()), 64'd6);
    check("rr_bubble", 64'(viol), 64'd0);
    for (int k = 0; k < got.size(); k++)
      check($sformatf("rr_grant%0d", k), 64'(got[k]), 64'((k % 3) + 1));

    // Sustained HP load on 0 with LP 1 waiting: eight HP grants, then one LP grant.
    do_reset();
    got.delete();
    for (int c = 0; c < 80 && got.size() < 18; c++) begin
      step(1'b1, 4'b0011, 4'b0011, 32'h0, 1'b1);
      if (busy) got.push_back(int'(gidx));
    end
    check("starve_count", 64'(got.size()), 64'd18);
    for (int k = 0; k < got.size(); k++)
      check($sformatf("starve_grant%0d", k), 64'(got[k]), 64'((k % 9 == 8) ? 1 : 0));

    // Granted input stalls for 5 cycles while input 3 keeps requesting.
    do_reset();
    step(1'b1, 4'b1001, 4'b0000, 32'h7, 1'b1);
    step(1'b1, 4'b1001, 4'b0000, 32'h7, 1'b1);
    check("hold_first_grant", 64'(gidx), 64'd0);
    check("hold_first_ready", 64'(rdy),  64'b0001);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'b1000, 4'b0000, 32'h8, 1'b1);
      check($sformatf("hold_gap%0d_valid", c), 64'(ovalid), 64'd0);
      check($sformatf("hold_gap%0d_grant", c), 64'(gidx),   64'd0);
      check($sformatf("hold_gap%0d_busy", c),  64'(busy),   64'd1);
      check($sformatf("hold_gap%0d_ready", c), 64'(rdy),    64'b0001);
    end
    step(1'b1, 4'b1001, 4'b0001, 32'h9, 1'b1);
    check("hold_last_valid", 64'(ovalid), 64'd1);
    check("hold_last_tlast", 64'(otlast), 64'd1);
    check("hold_last_data",  64'(dout),   64'h9);
    step(1'b1, 4'b1000, 4'b0000, 32'h0, 1'b1);
    check("hold_idle_busy", 64'(busy), 64'd0);
    step(1'b1, 4'b1000, 4'b1000, 32'h0, 1'b1);
    check("hold_next_grant", 64'(gidx), 64'd3);
    check("hold_next_busy",  64'(busy), 64'd1);

    // Reset during beat 2 of a packet, then a fresh arbitration from reset pointers.
    do_reset();
    step(1'b1, 4'b0010, 4'b0000, 32'h1, 1'b1);
    step(1'b1, 4'b0010, 4'b0000, 32'h1, 1'b1);
    step(1'b0, 4'b0010, 4'b0000, 32'h2, 1'b1);
    step(1'b1, 4'b0110, 4'b0110, 32'h3, 1'b1);
    check("rstmid_busy",  64'(busy),   64'd0);
    check("rstmid_ready", 64'(rdy),    64'd0);
    check("rstmid_valid", 64'(ovalid), 64'd0);
    check("rstmid_grant", 64'(gidx),   64'd0);
    step(1'b1, 4'b0110, 4'b0110, 32'h3, 1'b1);
    check("rstmid_regrant", 64'(gidx), 64'd1);
    check("rstmid_rebusy",  64'(busy), 64'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rs = ($urandom_range(0, 99) != 0);
      v  = N'($urandom);
      v[0] = ($urandom_range(0, 9) < 8);
      t  = N'($urandom) & N'($urandom);
      d  = $urandom;
      r  = ($urandom_range(0, 3) != 0);
      step(rs, v, t, d, r);
      g = m.grant;
      check("rand_busy",  64'(busy), 64'(m.locked));
      check("rand_grant", 64'(gidx), 64'(g));
      check("rand_valid", 64'(ovalid), m.locked ? 64'(v[g]) : 64'd0);
      check("rand_tlast", 64'(otlast), m.locked ? 64'(t[g]) : 64'd0);
      check("rand_ready", 64'(rdy), (m.locked && r) ? 64'(1 << g) : 64'd0);
      check("rand_data",  64'(dout), m.locked ? 64'(d ^ (DW'(g) << 28)) : 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
